// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Shares one combinational ALU between two requesters (req0 = EX stage,
//   req1 = branch/compare unit). Picks at most one requester per cycle,
//   drives the ALU inputs with its payload and captures the ALU result in a
//   one-entry output register with valid/ready handshaking.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> req1 always wins when both are valid
//                          undefined -> round-robin between the two requesters
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   req_valid / req_ready  per-requester handshake (bit i = requester i)
//   req{0,1}_a/_b          operands
//   req{0,1}_ctrl/_ctrl1   ALU control / branch code, passed through undecoded
//   alu_a/_b/_ctrl/_ctrl1  to the shared ALU (zero when nothing is granted)
//   alu_out                ALU result, combinational from alu_*
//   resp_valid/resp_ready  output register handshake
//   resp_id, resp_data     owner and value of the registered result
//   conflict_cnt           saturating count of cycles with both requesters valid
module alu_share_arb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic [2:0]       req0_ctrl1,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [3:0]       req1_ctrl,
    input  logic [2:0]       req1_ctrl1,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       alu_ctrl1,
    input  logic [XLEN-1:0]  alu_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [XLEN-1:0]  resp_data,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic              resp_id_q, resp_id_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

    logic              can_issue;
    logic              both_valid;
    logic              pick_id;
    logic [1:0]        grant;
    logic              grant_id;
    logic              accept;

    assign both_valid = &req_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign pick_id = 1'b1;
`else
    logic rr_ptr_q, rr_ptr_d;

    // Pointer only moves after a contended accept; it then favours the loser.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && both_valid) rr_ptr_d = ~grant_id;
    end

    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= 1'b0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    assign pick_id = rr_ptr_q;
`endif

    always_comb begin
        grant = req_valid;
        if (both_valid) grant = pick_id ? 2'b10 : 2'b01;
    end

    assign grant_id = grant[1];
    // Ready is held low during reset so a requester never sees its op taken
    // in a cycle whose result the reset would discard.
    assign req_ready = grant & {2{can_issue & ~reset}};
    assign accept    = |(req_valid & req_ready);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= EMPTY;
            resp_id_q      <= 1'b0;
            resp_data_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            resp_id_q      <= resp_id_d;
            resp_data_q    <= resp_data_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        resp_id_d      = resp_id_q;
        resp_data_d    = resp_data_q;
        conflict_cnt_d = conflict_cnt_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (resp_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            resp_id_d   = grant_id;
            resp_data_d = alu_out;
        end
        if (both_valid && !(&conflict_cnt_q)) conflict_cnt_d = conflict_cnt_q + CNT_ONE;
    end

    // Output logic
    always_comb begin
        resp_valid   = (state_q == FULL);
        can_issue    = ~resp_valid | resp_ready;
        resp_id      = resp_id_q;
        resp_data    = resp_data_q;
        conflict_cnt = conflict_cnt_q;
        alu_a        = '0;
        alu_b        = '0;
        alu_ctrl     = 4'b0;
        alu_ctrl1    = 3'b000;
        if (grant[0]) begin
            alu_a     = req0_a;
            alu_b     = req0_b;
            alu_ctrl  = req0_ctrl;
            alu_ctrl1 = req0_ctrl1;
        end else if (grant[1]) begin
            alu_a     = req1_a;
            alu_b     = req1_b;
            alu_ctrl  = req1_ctrl;
            alu_ctrl1 = req1_ctrl1;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [3:0] ALU_CTRL_ADD = 4'b0001;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0010;
    localparam logic [2:0] ALU_BLT      = 3'b100;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [XLEN-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       req0_ctrl, req1_ctrl;
    logic [2:0]       req0_ctrl1, req1_ctrl1;
    logic [XLEN-1:0]  alu_a, alu_b, alu_out;
    logic [3:0]       alu_ctrl;
    logic [2:0]       alu_ctrl1;
    logic             resp_valid, resp_ready, resp_id;
    logic [XLEN-1:0]  resp_data;
    logic [CNT_W-1:0] conflict_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl), .req0_ctrl1(req0_ctrl1),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl), .req1_ctrl1(req1_ctrl1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_ctrl1(alu_ctrl1),
        .alu_out(alu_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .conflict_cnt(conflict_cnt)
    );

    // Stand-in for the shared ALU (subset of operations used below)
    always_comb begin
        alu_out = '0;
        if (alu_ctrl1 == ALU_BLT)
            alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
        else if (alu_ctrl == ALU_CTRL_ADD)
            alu_out = alu_a + alu_b;
        else if (alu_ctrl == ALU_CTRL_SUB)
            alu_out = alu_a - alu_b;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_ctrl = 4'b0; req0_ctrl1 = 3'b0;
        req1_a = '0; req1_b = '0; req1_ctrl = 4'b0; req1_ctrl1 = 3'b0;
        step(); step();
        reset = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %0h expected 0", resp_valid); else passed++;
        total++; if (resp_id !== 1'b0) $display("FAIL reset_resp_id: got %0h expected 0", resp_id); else passed++;
        total++; if (resp_data !== 32'd0) $display("FAIL reset_resp_data: got %0h expected 0", resp_data); else passed++;
        total++; if (conflict_cnt !== 4'd0) $display("FAIL reset_conflict_cnt: got %0h expected 0", conflict_cnt); else passed++;
        total++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %0b expected 00", req_ready); else passed++;
        total++; if (alu_a !== 32'd0 || alu_ctrl !== 4'd0) $display("FAIL reset_alu_idle: got a=%0h ctrl=%0h expected 0/0", alu_a, alu_ctrl); else passed++;
    endtask

    task automatic test_single();
        req_valid = 2'b01; req0_a = 32'd5; req0_b = 32'd7;
        req0_ctrl = ALU_CTRL_ADD; req0_ctrl1 = 3'b000; resp_ready = 1'b0;
        #1;
        total++; if (req_ready !== 2'b01) $display("FAIL single_req_ready: got %0b expected 01", req_ready); else passed++;
        total++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_ctrl !== ALU_CTRL_ADD || alu_ctrl1 !== 3'b000)
            $display("FAIL single_alu_drive: got a=%0h b=%0h ctrl=%0h ctrl1=%0h expected 5/7/%0h/0", alu_a, alu_b, alu_ctrl, alu_ctrl1, ALU_CTRL_ADD);
        else passed++;
        step();
        req_valid = 2'b00;
        total++; if (resp_valid !== 1'b1) $display("FAIL single_resp_valid: got %0h expected 1", resp_valid); else passed++;
        total++; if (resp_id !== 1'b0) $display("FAIL single_resp_id: got %0h expected 0", resp_id); else passed++;
        total++; if (resp_data !== 32'd12) $display("FAIL single_resp_data: got %0d expected 12", resp_data); else passed++;
    endtask

    task automatic test_backpressure();
        req_valid = 2'b01; req0_a = 32'd10; req0_b = 32'd3; req0_ctrl = ALU_CTRL_SUB;
        #1;
        total++; if (req_ready !== 2'b00) $display("FAIL bp_stall_ready: got %0b expected 00", req_ready); else passed++;
        step();
        total++; if (resp_data !== 32'd12 || resp_valid !== 1'b1) $display("FAIL bp_hold: got data=%0d valid=%0h expected 12/1", resp_data, resp_valid); else passed++;
        resp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) $display("FAIL bp_passthru_ready: got %0b expected 01", req_ready); else passed++;
        step();
        req_valid = 2'b00;
        total++; if (resp_data !== 32'd7 || resp_id !== 1'b0 || resp_valid !== 1'b1)
            $display("FAIL bp_refill: got data=%0d id=%0h valid=%0h expected 7/0/1", resp_data, resp_id, resp_valid);
        else passed++;
        step();
        total++; if (resp_valid !== 1'b0) $display("FAIL bp_drain: got %0h expected 0", resp_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic exp_id;
        req0_a = 32'd1;  req0_b = 32'd1; req0_ctrl = ALU_CTRL_ADD; req0_ctrl1 = 3'b000;
        req1_a = 32'd20; req1_b = 32'd5; req1_ctrl = ALU_CTRL_SUB; req1_ctrl1 = 3'b000;
        req_valid = 2'b11; resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b1;
`else
            exp_id = (k % 2 == 1);
`endif
            #1;
            total++; if (req_ready !== (exp_id ? 2'b10 : 2'b01))
                $display("FAIL b2b_grant[%0d]: got %0b expected %0b", k, req_ready, exp_id ? 2'b10 : 2'b01);
            else passed++;
            step();
            total++; if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_data !== (exp_id ? 32'd15 : 32'd2))
                $display("FAIL b2b_resp[%0d]: got valid=%0h id=%0h data=%0d expected 1/%0h/%0d", k, resp_valid, resp_id, resp_data, exp_id, exp_id ? 15 : 2);
            else passed++;
        end
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) $display("FAIL b2b_req0_after_drop: got %0b expected 01", req_ready); else passed++;
        total++; if (conflict_cnt !== 4'd4) $display("FAIL b2b_conflict_cnt: got %0d expected 4", conflict_cnt); else passed++;
        step();
        req_valid = 2'b00;
        total++; if (resp_id !== 1'b0 || resp_data !== 32'd2) $display("FAIL b2b_last: got id=%0h data=%0d expected 0/2", resp_id, resp_data); else passed++;
        step();
    endtask

    task automatic test_branch();
        req_valid = 2'b10; resp_ready = 1'b1;
        req1_a = 32'hFFFF_FFFD; req1_b = 32'd2; req1_ctrl = ALU_CTRL_ADD; req1_ctrl1 = ALU_BLT;
        #1;
        total++; if (req_ready !== 2'b10) $display("FAIL br_ready: got %0b expected 10", req_ready); else passed++;
        total++; if (alu_ctrl1 !== ALU_BLT || alu_a !== 32'hFFFF_FFFD) $display("FAIL br_passthru: got ctrl1=%0h a=%0h expected %0h/fffffffd", alu_ctrl1, alu_a, ALU_BLT); else passed++;
        step();
        total++; if (resp_id !== 1'b1 || resp_data !== 32'd1) $display("FAIL br_lt_true: got id=%0h data=%0d expected 1/1", resp_id, resp_data); else passed++;
        req1_a = 32'd2; req1_b = 32'hFFFF_FFFD;
        step();
        req_valid = 2'b00;
        total++; if (resp_id !== 1'b1 || resp_data !== 32'd0) $display("FAIL br_lt_false: got id=%0h data=%0d expected 1/0", resp_id, resp_data); else passed++;
        step();
    endtask

    task automatic test_saturation();
        req_valid = 2'b11; resp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 9) begin
                total++; if (conflict_cnt !== 4'd14) $display("FAIL sat_mid: got %0d expected 14", conflict_cnt); else passed++;
            end
        end
        total++; if (conflict_cnt !== 4'hF) $display("FAIL sat_hold: got %0h expected f", conflict_cnt); else passed++;
        req_valid = 2'b00;
        step();
        total++; if (conflict_cnt !== 4'hF) $display("FAIL sat_idle: got %0h expected f", conflict_cnt); else passed++;
    endtask

    task automatic test_reset_midstall();
        logic [1:0] exp_ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_ready = 2'b10;
`else
        exp_ready = 2'b01;
`endif
        resp_ready = 1'b0; req_valid = 2'b11;
        step();
        total++; if (resp_valid !== 1'b1 || req_ready !== 2'b00) $display("FAIL rst_stall_setup: got valid=%0h ready=%0b expected 1/00", resp_valid, req_ready); else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_data !== 32'd0)
            $display("FAIL rst_stall_regs: got valid=%0h id=%0h data=%0h expected 0/0/0", resp_valid, resp_id, resp_data);
        else passed++;
        total++; if (conflict_cnt !== 4'd0) $display("FAIL rst_stall_cnt: got %0d expected 0", conflict_cnt); else passed++;
        #1;
        total++; if (req_ready !== exp_ready) $display("FAIL rst_first_grant: got %0b expected %0b", req_ready, exp_ready); else passed++;
        step();
        req_valid = 2'b00;
        total++; if (resp_valid !== 1'b1 || resp_id !== exp_ready[1]) $display("FAIL rst_first_resp: got valid=%0h id=%0h expected 1/%0h", resp_valid, resp_id, exp_ready[1]); else passed++;
        total++; if (conflict_cnt !== 4'd1) $display("FAIL rst_cnt_restart: got %0d expected 1", conflict_cnt); else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_branch();
        test_saturation();
        test_reset_midstall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
